instr_fetch_unit: RTL

//   Fetch stage ahead of the single-cycle decode/execute core. Owns the fetch PC and issues
//   in-order word reads to instruction memory (request/grant, variable-latency response).

---
 rtl/instr_fetch_unit_pkg.sv | 30 +++
 rtl/instr_fetch_unit_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, queue entry layout and PC helpers.
package instr_fetch_unit_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP     = 32'h0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } ifu_entry_t;

    // Observation bundle so checkers can bind to the FSM and PCs by name.
    typedef struct packed {
        ifu_state_e  state;
        logic [31:0] fetch_pc;
        logic [31:0] resp_pc;
    } ifu_dbg_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch queue: DEPTH x {pc, instr} synchronous FIFO with flush and a
// combinational head read. Pop on empty is ignored; push on full is illegal.
module ifu_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  ifu_entry_t       din,
    input  logic             pop,
    input  logic             flush,
    output ifu_entry_t       dout,
    output logic [CW-1:0]    count
);

    ifu_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word reads under a credit
// limit, queues responses and hands {pc, instr} to decode; redirect squashes.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a transfer happens on a cycle where valid(req) and ready(gnt)
    // are both high; valid never depends on ready on the same interface.
    ifu_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    ifu_entry_t    head, push_entry;
    logic          issue, rsp, push, pop;
    ifu_dbg_t      dbg;

    assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req   = rst_n && (state_q == ST_FETCH) && (inflight < (CW+1)'(DEPTH)) && !redirect;
    assign imem_addr  = fetch_pc_q;
    assign issue      = imem_req && imem_gnt;
    // Responses with nothing outstanding are stray and never counted.
    assign rsp        = imem_rvalid && (outstanding_q != '0);
    assign push       = rsp && (state_q == ST_FETCH) && !redirect;
    assign pop        = if_valid && if_ready;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    assign if_valid = rst_n && (fifo_count != '0);
    assign if_instr = if_valid ? head.instr : NOP;
    assign if_pc    = if_valid ? head.pc    : 32'h0;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
        if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (push)  resp_pc_d  = resp_pc_q + PC_STEP;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            state_d    = (outstanding_d != '0) ? ST_DRAIN : ST_FETCH;
        end else if (state_q == ST_DRAIN && outstanding_d == '0) begin
            state_d = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (redirect),
        .dout  (head),
        .count (fifo_count)
    );

    assign dbg = '{state: state_q, fetch_pc: fetch_pc_q, resp_pc: resp_pc_q};

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && outstanding_q == '0));

endmodule
